alu_seq: RTL and testbench

Parametrised, handshaked successor to the combinational 8-bit `alu`. It accepts one command per transaction over a valid/ready input port and holds the registered result and flags on a valid/ready output port until they are consumed. It adds XOR, shifts, a multi-cycle shift-add multiplier, status flags and illegal-command detection. It sits between an instruction/operand source and a result consumer that may apply backpressure.

---
 rtl/alu_seq.sv | 183 ++++++++++++++++++
 tb/tb_alu_seq.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered result/flags and a multi-cycle
// shift-add multiplier. One command per valid/ready transaction; the result
// is held on the output port until the consumer takes it.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | nothing in flight, ready for a command when enabled
//   MUL     | shift-add multiply running, one multiplier bit per cycle
//   DONE    | result and flags presented, waiting for out_ready
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 enable_in,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    input  logic [3:0]           command_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [2*WIDTH-1:0]   out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 flag_carry,
    output logic                 flag_zero,
    output logic                 flag_err
);

    localparam int DW = 2 * WIDTH;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_NOT = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_SHL = 4'b0110;
    localparam logic [3:0] OP_SHR = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DW-1:0]       out_q, out_d;
    logic                carry_q, carry_d;
    logic                zero_q, zero_d;
    logic                err_q, err_d;
    logic [DW-1:0]       acc_q, acc_d;
    logic [DW-1:0]       mcand_q, mcand_d;
    logic [WIDTH-1:0]    mplier_q, mplier_d;
    logic [SHW-1:0]      cnt_q, cnt_d;

    logic                accept;
    logic [SHW-1:0]      shamt;
    logic [WIDTH:0]      add_res;
    logic [DW-1:0]       op_res;
    logic                op_carry;
    logic                op_err;
    logic [DW-1:0]       acc_sum;

    // Ready never depends on in_valid, so the source can't form a comb loop.
    always_comb begin
        in_ready = enable_in &&
                   ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
    end

    assign accept     = in_valid && in_ready;
    assign shamt      = b_in[SHW-1:0];
    assign add_res    = {1'b0, a_in} + {1'b0, b_in};
    assign acc_sum    = acc_q + (mplier_q[0] ? mcand_q : '0);

    assign out        = out_q;
    assign out_valid  = (state_q == ST_DONE);
    assign flag_carry = carry_q;
    assign flag_zero  = zero_q;
    assign flag_err   = err_q;

    // Single-cycle opcode results, zero-extended to the full output width.
    always_comb begin
        op_res   = '0;
        op_carry = 1'b0;
        op_err   = 1'b0;
        case (command_in)
            OP_ADD: begin
                op_res[WIDTH:0] = add_res;
                op_carry        = add_res[WIDTH];
            end
            OP_SUB: begin
                op_res[WIDTH-1:0] = a_in - b_in;
                op_carry          = (a_in < b_in);
            end
            OP_AND: op_res[WIDTH-1:0] = a_in & b_in;
            OP_OR:  op_res[WIDTH-1:0] = a_in | b_in;
            OP_NOT: op_res[WIDTH-1:0] = ~a_in;
            OP_XOR: op_res[WIDTH-1:0] = a_in ^ b_in;
            OP_SHL: op_res = {{WIDTH{1'b0}}, a_in} << shamt;
            OP_SHR: op_res[WIDTH-1:0] = a_in >> shamt;
            OP_MUL: op_res = '0;
            default: op_err = 1'b1;
        endcase
    end

    // Next-state, multiplier datapath and output capture.
    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        err_d    = err_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    if (command_in == OP_MUL) begin
                        state_d  = ST_MUL;
                        acc_d    = '0;
                        mcand_d  = {{WIDTH{1'b0}}, a_in};
                        mplier_d = b_in;
                        cnt_d    = SHW'(WIDTH - 1);
                    end else begin
                        state_d = ST_DONE;
                        out_d   = op_res;
                        carry_d = op_carry;
                        zero_d  = (op_res == '0);
                        err_d   = op_err;
                    end
                end else if (state_q == ST_DONE && out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    out_d   = acc_sum;
                    carry_d = 1'b0;
                    zero_d  = (acc_sum == '0);
                    err_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - SHW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= ST_IDLE;
            out_q    <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=8): directed vectors, multiplier latency,
// backpressure, illegal opcodes, enable gating, async reset and a randomized
// run against a transaction-level reference model.
module tb_alu_seq;

    localparam int W = 8;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [3:0]    cmd;
    logic          in_valid;
    logic          out_ready;
    logic          in_ready;
    logic [2*W-1:0] dout;
    logic          out_valid;
    logic          fc;
    logic          fz;
    logic          fe;

    int checks = 0;
    int errors = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk_in     (clk),
        .rst_n_in   (rst_n),
        .enable_in  (enable),
        .a_in       (a),
        .b_in       (b),
        .command_in (cmd),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out        (dout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .flag_carry (fc),
        .flag_zero  (fz),
        .flag_err   (fe)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: plain integer arithmetic per opcode.
    function automatic void model(input int av, input int bv, input int cv,
                                  output logic [15:0] r, output logic c,
                                  output logic z, output logic e);
        int t;
        t = 0;
        c = 1'b0;
        e = 1'b0;
        case (cv)
            0: begin t = av + bv; c = (t > 255); end
            1: begin t = (av - bv + 256) % 256; c = (av < bv); end
            2: t = av & bv;
            3: t = av | bv;
            4: t = 255 - av;
            5: t = av ^ bv;
            6: t = av * (1 << (bv % 8));
            7: t = av / (1 << (bv % 8));
            8: t = av * bv;
            default: begin t = 0; e = 1'b1; end
        endcase
        r = t[15:0];
        z = (t == 0);
    endfunction

    typedef struct {
        int a; int b; int c; int o; int fc; int fz;
    } vec_t;

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cmd = '0;
        #23;
        checks++;
        if (out_valid !== 1'b0 || dout !== 16'h0 || fc !== 1'b0 || fz !== 1'b0 || fe !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%b out=%h c=%b z=%b e=%b, want 0/0000/0/0/0",
                     out_valid, dout, fc, fz, fe);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: in_ready=%b want 1", in_ready);
        end
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        vec_t v[$];
        v.push_back('{200, 100, 0, 16'h012C, 1, 0});
        v.push_back('{20,  30,  1, 16'h00F6, 1, 0});
        v.push_back('{30,  20,  1, 10,       0, 0});
        v.push_back('{6,   4,   2, 4,        0, 0});
        v.push_back('{6,   4,   3, 6,        0, 0});
        v.push_back('{6,   4,   5, 2,        0, 0});
        v.push_back('{6,   4,   4, 16'h00F9, 0, 0});
        v.push_back('{255, 7,   6, 16'h7F80, 0, 0});
        v.push_back('{128, 3,   7, 16'h0010, 0, 0});
        v.push_back('{0,   0,   0, 0,        0, 1});
        v.push_back('{5,   5,   1, 0,        0, 1});
        v.push_back('{1,   15,  6, 16'h0080, 0, 0});
        v.push_back('{255, 1,   0, 16'h0100, 1, 0});
        foreach (v[i]) begin
            @(negedge clk);
            a = v[i].a[7:0]; b = v[i].b[7:0]; cmd = v[i].c[3:0];
            in_valid = 1'b1; out_ready = 1'b1;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL dir_ready[%0d]: in_ready=%b want 1", i, in_ready);
            end
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || dout !== v[i].o[15:0] || fc !== v[i].fc[0] ||
                fz !== v[i].fz[0] || fe !== 1'b0) begin
                errors++;
                $display("FAIL dir_result[%0d]: valid=%b out=%h c=%b z=%b e=%b, want 1/%h/%0d/%0d/0",
                         i, out_valid, dout, fc, fz, fe, v[i].o[15:0], v[i].fc, v[i].fz);
            end
        end
        @(negedge clk) in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || dout !== 16'h0100) begin
            errors++;
            $display("FAIL dir_drain: valid=%b out=%h, want 0/0100", out_valid, dout);
        end
    endtask

    task automatic test_mul();
        int n;
        @(negedge clk);
        a = 8'd255; b = 8'd255; cmd = 4'b1000; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < W; k++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL mul_busy[%0d]: in_ready=%b valid=%b, want 0/0", k, in_ready, out_valid);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (out_valid !== 1'b1 || dout !== 16'hFE01 || fz !== 1'b0 || fc !== 1'b0 || fe !== 1'b0) begin
            errors++;
            $display("FAIL mul_255x255: valid=%b out=%h z=%b c=%b e=%b, want 1/fe01/0/0/0",
                     out_valid, dout, fz, fc, fe);
        end
        @(negedge clk);
        a = 8'd0; b = 8'd77; cmd = 4'b1000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n != W || dout !== 16'h0 || fz !== 1'b1) begin
            errors++;
            $display("FAIL mul_zero: latency=%0d out=%h z=%b, want %0d/0000/1", n, dout, fz, W);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        a = 8'd1; b = 8'd2; cmd = 4'b0000; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            a = 8'd9; b = 8'd4; cmd = 4'b0001; in_valid = 1'b1; out_ready = 1'b0;
            #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || dout !== 16'd3) begin
                errors++;
                $display("FAIL bp_hold[%0d]: in_ready=%b valid=%b out=%h, want 0/1/0003",
                         k, in_ready, out_valid, dout);
            end
            @(posedge clk); #1;
        end
        @(negedge clk) out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: in_ready=%b want 1", in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || dout !== 16'd5 || fc !== 1'b0) begin
            errors++;
            $display("FAIL bp_b2b: valid=%b out=%h c=%b, want 1/0005/0", out_valid, dout, fc);
        end
        @(negedge clk) in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_illegal_enable();
        @(negedge clk);
        a = 8'($urandom); b = 8'($urandom); cmd = 4'b1111; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || dout !== 16'h0 || fe !== 1'b1 || fz !== 1'b1 || fc !== 1'b0) begin
            errors++;
            $display("FAIL illegal_op: valid=%b out=%h e=%b z=%b c=%b, want 1/0000/1/1/0",
                     out_valid, dout, fe, fz, fc);
        end
        @(negedge clk);
        a = 8'd1; b = 8'd1; cmd = 4'b0000;
        @(posedge clk); #1;
        checks++;
        if (dout !== 16'd2 || fe !== 1'b0 || fz !== 1'b0) begin
            errors++;
            $display("FAIL illegal_clear: out=%h e=%b z=%b, want 0002/0/0", dout, fe, fz);
        end
        @(negedge clk) in_valid = 1'b0;
        @(negedge clk);
        enable = 1'b0; in_valid = 1'b1; a = 8'd7; b = 8'd7; cmd = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL enable_ready[%0d]: in_ready=%b want 0", k, in_ready);
            end
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0 || dout !== 16'd2) begin
                errors++;
                $display("FAIL enable_noaccept[%0d]: valid=%b out=%h, want 0/0002", k, out_valid, dout);
            end
            @(negedge clk);
        end
        in_valid = 1'b0; enable = 1'b1;
    endtask

    task automatic test_random();
        bit          have;
        int          mul_left;
        logic [15:0] last_o, p_o, r_o;
        logic        last_c, last_z, last_e, p_c, p_z, p_e, r_c, r_z, r_e;
        bit          exp_ready;
        @(negedge clk) rst_n = 1'b0;
        #2 rst_n = 1'b1;
        have = 0; mul_left = 0;
        last_o = '0; last_c = 0; last_z = 0; last_e = 0;
        p_o = '0; p_c = 0; p_z = 0; p_e = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            enable    = ($urandom_range(0, 9) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a   = 8'($urandom);
            b   = 8'($urandom);
            cmd = ($urandom_range(0, 5) == 0) ? 4'b1000 : 4'($urandom);
            exp_ready = enable && ((!have && mul_left == 0) || (have && out_ready));
            #1;
            checks++;
            if (in_ready !== exp_ready) begin
                errors++;
                $display("FAIL rnd_ready[%0d]: in_ready=%b want %b", cyc, in_ready, exp_ready);
            end
            @(posedge clk);
            if (have && out_ready) have = 0;
            if (in_valid && exp_ready) begin
                model(int'(a), int'(b), int'(cmd), r_o, r_c, r_z, r_e);
                if (cmd == 4'b1000) begin
                    mul_left = W;
                    p_o = r_o; p_c = r_c; p_z = r_z; p_e = r_e;
                end else begin
                    have = 1;
                    last_o = r_o; last_c = r_c; last_z = r_z; last_e = r_e;
                end
            end else if (mul_left > 0) begin
                mul_left--;
                if (mul_left == 0) begin
                    have = 1;
                    last_o = p_o; last_c = p_c; last_z = p_z; last_e = p_e;
                end
            end
            #1;
            checks++;
            if (out_valid !== have || dout !== last_o || fc !== last_c ||
                fz !== last_z || fe !== last_e) begin
                errors++;
                $display("FAIL rnd_out[%0d]: valid=%b out=%h c=%b z=%b e=%b, want %b/%h/%b/%b/%b",
                         cyc, out_valid, dout, fc, fz, fe, have, last_o, last_c, last_z, last_e);
            end
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1; enable = 1'b1;
        repeat (W + 3) @(negedge clk);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        a = 8'd5; b = 8'd6; cmd = 4'b0000; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        a = 8'd200; b = 8'd3; cmd = 4'b1000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || dout !== 16'h0 || fc !== 1'b0 || fz !== 1'b0 || fe !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: valid=%b out=%h c=%b z=%b e=%b, want 0/0000/0/0/0",
                     out_valid, dout, fc, fz, fe);
        end
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < W + 2; k++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0 || dout !== 16'h0) begin
                errors++;
                $display("FAIL async_discard[%0d]: valid=%b out=%h, want 0/0000", k, out_valid, dout);
            end
        end
        @(negedge clk);
        a = 8'd5; b = 8'd5; cmd = 4'b0000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || dout !== 16'd10 || fc !== 1'b0 || fz !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_add: valid=%b out=%h c=%b z=%b, want 1/000a/0/0",
                     out_valid, dout, fc, fz);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mul();
        test_backpressure();
        test_illegal_enable();
        test_random();
        test_async_reset();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
